// File: rtl/pwm_actuator.sv
// pwm_actuator: signed command to sign/magnitude PWM drive with a per-period sample strobe.
// Optional slew limiting of the applied command is enabled by defining PWM_SLEW_LIMIT_EN.
module pwm_actuator #(
    parameter int CNT_W = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic signed [15:0] cmd,
    input  logic [CNT_W-1:0]   period,
    input  logic [15:0]        max_step,
    output logic               sample_en,
    output logic               pwm_out,
    output logic               dir,
    output logic [CNT_W:0]     duty,
    output logic               sat
);
    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d;
    logic signed [15:0] applied_q, applied_d, target;
    logic [CNT_W:0] duty_q, duty_d, raw, limit;
    logic [15:0] mag;
    logic dir_q, dir_d, sat_q, sat_d, pwm_q, pwm_d, wrap, latch;
`ifdef PWM_SLEW_LIMIT_EN
    logic signed [16:0] diff, step;
    always_comb begin
        diff = {cmd[15], cmd} - {applied_q[15], applied_q};
        step = {1'b0, max_step};
        target = diff > step ? applied_q + max_step : diff < -step ? applied_q - max_step : cmd;
    end
`else
    logic unused_max_step;
    assign unused_max_step = ^max_step;
    assign target = cmd;
`endif
    always_comb begin
        wrap = cnt_q == period_q;
        latch = (state_q == IDLE && enable) || (state_q == RUN && wrap);
        unique case (state_q)
            IDLE:    state_d = enable ? RUN : IDLE;
            RUN:     state_d = enable ? RUN : STOP;
            STOP:    state_d = wrap ? IDLE : enable ? RUN : STOP;
            default: state_d = IDLE;
        endcase
        cnt_d = (state_q == IDLE || wrap) ? '0 : cnt_q + 1'b1;
        period_d = latch ? period : period_q;
        applied_d = latch ? target : applied_q;
        // -32768 has no positive twin; treat it as full scale and flag it
        mag = applied_d == -16'sd32768 ? 16'd32767 : applied_d[15] ? 16'(-applied_d) : applied_d;
        raw = (CNT_W+1)'(mag >> (15 - CNT_W));
        limit = {1'b0, period_d} + 1'b1;
        duty_d = latch ? (raw > limit ? limit : raw) : duty_q;
        dir_d = latch ? applied_d[15] : dir_q;
        sat_d = latch ? (raw > limit || applied_d == -16'sd32768) : sat_q;
        pwm_d = state_d != IDLE && {1'b0, cnt_d} < duty_d;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            applied_q <= '0;
            duty_q    <= '0;
            dir_q     <= 1'b0;
            sat_q     <= 1'b0;
            pwm_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            applied_q <= applied_d;
            duty_q    <= duty_d;
            dir_q     <= dir_d;
            sat_q     <= sat_d;
            pwm_q     <= pwm_d;
        end
    end
    assign sample_en = state_q == RUN && wrap;
    assign pwm_out = pwm_q;
    assign dir = dir_q;
    assign duty = duty_q;
    assign sat = sat_q;
endmodule

// File: tb/tb_pwm_actuator.sv
// tb_pwm_actuator: directed checks of pwm_actuator with CNT_W=10.
module tb_pwm_actuator;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    logic signed [15:0] cmd = 16'sd16384;
    logic [9:0] period = 10'd1023;
    logic [15:0] max_step = 16'hFFFF;
    logic sample_en, pwm_out, dir, sat;
    logic [10:0] duty;
    int n_chk = 0;
    int n_fail = 0;
    int highs, pulses, pulse_at;

    pwm_actuator #(.CNT_W(10)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .cmd(cmd), .period(period),
        .max_step(max_step), .sample_en(sample_en), .pwm_out(pwm_out), .dir(dir),
        .duty(duty), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // samples n consecutive cycles, counting pwm highs and sample_en pulses
    task automatic run(input int n, input int cmd_at, input logic signed [15:0] new_cmd);
        highs = 0;
        pulses = 0;
        pulse_at = -1;
        for (int i = 0; i < n; i++) begin
            if (i == cmd_at) cmd = new_cmd;
            highs += int'(pwm_out);
            if (sample_en) begin
                pulses++;
                pulse_at = i;
            end
            step(1);
        end
    endtask

    initial begin
        step(2);
        check("rst_pwm", pwm_out, 0);
        check("rst_sample", sample_en, 0);
        check("rst_duty", duty, 0);
        check("rst_dir", dir, 0);
        check("rst_sat", sat, 0);
        reset_n = 1'b1;
        step(2);
        check("idle_pwm", pwm_out, 0);
        enable = 1'b1;
        step(1);
        check("basic_duty", duty, 512);
        check("basic_first_pwm", pwm_out, 1);
        check("basic_dir", dir, 0);
        check("basic_sat", sat, 0);
        run(1024, -1, 0);
        check("basic_highs", highs, 512);
        check("basic_pulses", pulses, 1);
        check("basic_pulse_pos", pulse_at, 1023);
        run(1024, 300, 16'sd8192);
        check("bound_cur_highs", highs, 512);
        check("bound_cur_duty_hold", duty, 256);
        run(1024, -1, 0);
        check("bound_next_highs", highs, 256);
        cmd = -16'sd32768;
        step(1024);
        check("negfs_duty", duty, 1023);
        check("negfs_dir", dir, 1);
        check("negfs_sat", sat, 1);
        run(1024, 0, -16'sd16384);
        check("negfs_highs", highs, 1023);
        check("neg_duty", duty, 512);
        check("neg_dir", dir, 1);
        check("neg_sat", sat, 0);
        step(200);
        enable = 1'b0;
        run(824, -1, 0);
        check("stop_highs", highs, 312);
        check("stop_pulses", pulses, 0);
        check("stop_idle_pwm", pwm_out, 0);
        check("stop_duty_hold", duty, 512);
        step(3);
        check("idle_sample", sample_en, 0);
        enable = 1'b1;
        step(1);
        check("restart_pwm", pwm_out, 1);
        step(1022);
        check("restart_pre_pulse", sample_en, 0);
        step(1);
        check("restart_pulse", sample_en, 1);
        period = 10'd99;
        cmd = 16'sd16384;
        step(1);
        check("clamp_duty", duty, 100);
        check("clamp_sat", sat, 1);
        check("clamp_dir", dir, 0);
        run(100, -1, 0);
        check("clamp_highs", highs, 100);
        check("clamp_pulses", pulses, 1);
        check("clamp_pulse_pos", pulse_at, 99);
        period = 10'd0;
        step(100);
        check("p0_duty", duty, 1);
        run(10, -1, 0);
        check("p0_pulses", pulses, 10);
        check("p0_highs", highs, 10);
        cmd = 16'sd0;
        step(2);
        check("zero_duty", duty, 0);
        check("zero_dir", dir, 0);
        check("zero_pwm", pwm_out, 0);
        check("zero_sat", sat, 0);
        period = 10'd9;
        step(1);
        step(3);
        enable = 1'b0;
        step(2);
        enable = 1'b1;
        step(3);
        check("blip_pre_pulse", sample_en, 0);
        step(1);
        check("blip_pulse", sample_en, 1);
        period = 10'd1023;
        cmd = 16'sd5000;
`ifdef PWM_SLEW_LIMIT_EN
        max_step = 16'd1000;
        step(1);
        check("slew_first", duty, 31);
        step(1024);
        check("slew_second", duty, 62);
        step(3072);
        check("slew_final", duty, 156);
        step(1024);
        check("slew_hold", duty, 156);
`else
        step(1);
        check("noslew_first", duty, 156);
        step(1024);
        check("noslew_hold", duty, 156);
`endif
        step(100);
        check("pre_reset_pwm", pwm_out, 1);
        reset_n = 1'b0;
        #1;
        check("async_pwm", pwm_out, 0);
        check("async_duty", duty, 0);
        check("async_sample", sample_en, 0);
        check("async_sat", sat, 0);
        check("async_dir", dir, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
